audio_pwm_dac: RTL and testbench
================================

AUDIO_PWM_DAC -- requirements
Module: audio_pwm_dac

Interface
REQ-001 Parameter WIDTH, default 12: duty-cycle and PWM counter width; PWM period is 2^WIDTH clk cycles.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: flops in the req synchronizer chain.
REQ-003 clk  input  1: PWM clock (150 MHz pwm_clk_g), the only clock; all state on its rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 rv_duty_cycle  input  WIDTH: duty value from the CPU clock domain, held stable by the initiator while req is high.
REQ-006 req  input  1: four-phase request from the CPU clock domain, asynchronous to clk.
REQ-007 ack  output  1: four-phase acknowledge, registered, driven from clk.
REQ-008 pwm  output  1: registered PWM output.

Function
REQ-009 req SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (req_s) is used by logic; rv_duty_cycle is sampled unsynchronized, only on a capture edge.
REQ-010 Handshake FSM: IDLE (ack=0) and ACKED (ack=1); IDLE->ACKED when req_s=1; ACKED->IDLE when req_s=0; no other transitions.
REQ-011 On the IDLE->ACKED edge: capture rv_duty_cycle into pending_duty; set pending_valid=1.
REQ-012 Latency: counting the first edge that samples req=1 as edge 1, ack SHALL be high after edge SYNC_STAGES+1 (edge 3 at default); ack drop after req falls has the same latency.
REQ-013 ack SHALL NOT rise again until req_s has been observed low (no double capture per request).
REQ-014 Free-running WIDTH-bit counter increments every cycle and wraps from 2^WIDTH-1 to 0.
REQ-015 pwm SHALL be registered as (counter < active_duty): duty 0 gives constant 0; duty D gives exactly D high cycles per period; maximum duty gives 2^WIDTH-1 high cycles.
REQ-016 Each period's high cycles SHALL be contiguous, starting with the cycle after counter=0 is presented (one-cycle register delay).
REQ-017 Update policy per Configuration; a pending capture arriving on the same edge as a wrap SHALL be applied at the following wrap (buffered mode).
REQ-018 Multiple captures before an update: the last captured value wins; earlier values are discarded.

Reset
REQ-019 While rst=1 (asynchronous): sync chain=0, state=IDLE, ack=0, counter=0, active_duty=0, pending_duty=0, pending_valid=0, pwm=0.
REQ-020 Reset during ACKED SHALL drop ack immediately; after release, a still-high req SHALL be captured anew after SYNC_STAGES+1 edges.
REQ-021 Reset release needs no synchronization beyond the caller's reset synchronizer; first active edge after release counts as edge 1.

Configuration
REQ-022 Macro AUDIO_PWM_DAC_DOUBLE_BUFFER_EN defined: active_duty <= pending_duty only on the counter wrap edge when pending_valid=1, clearing pending_valid (glitch-free periods).
REQ-023 Macro undefined: active_duty SHALL load rv_duty_cycle on the same edge as capture (REQ-011); pending_valid is unused; the current period may be truncated or extended.
REQ-024 Handshake timing (REQ-012) SHALL be identical in both builds.

Verification
REQ-025 Reset, duty=0 -> pwm=0 for 3 full periods (12288 cycles); ack=0.
REQ-026 Set rv_duty_cycle=1024, raise req -> ack=1 after edge 3; drop req -> ack=0 after edge 3; buffered build: next full period has exactly 1024 high cycles.
REQ-027 Duty 4095 then 1 -> periods with 4095 and 1 high cycles; one low cycle per period at 4095.
REQ-028 Buffered build: two handshakes (500, then 3000) within one period -> next period high 3000 cycles; 500 never appears.
REQ-029 Capture timed to the wrap edge -> buffered build applies the value one period later (REQ-017).
REQ-030 Assert rst while ack=1 and req=1, release after 5 cycles -> ack low immediately, re-asserts after edge 3, pwm=0 until the next applied duty.

Source files
------------

// File: rtl/audio_pwm_dac.sv
// Audio PWM DAC: four-phase req/ack duty-cycle handshake from a foreign clock domain, free-running PWM.
// Define AUDIO_PWM_DAC_DOUBLE_BUFFER_EN to defer duty updates to the counter wrap (glitch-free periods).
module audio_pwm_dac #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rv_duty_cycle,
  input  logic             req,
  output logic             ack,
  output logic             pwm
);

  typedef enum logic {IDLE, ACKED} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   req_s;
  logic                   capture;
  logic                   wrap;
  logic [WIDTH-1:0]       counter;
  logic [WIDTH-1:0]       active_duty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], req};
  end

  assign req_s = sync[SYNC_STAGES-1];

  // capture fires only on IDLE->ACKED, so one request yields exactly one sample
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:    if (req_s) begin
                 state_nxt = ACKED;
                 capture   = 1'b1;
               end
      ACKED:   if (!req_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign ack = (state == ACKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) counter <= '0;
    else     counter <= counter + 1'b1;
  end

  assign wrap = (counter == {WIDTH{1'b1}});

`ifdef AUDIO_PWM_DAC_DOUBLE_BUFFER_EN
  logic [WIDTH-1:0] pending_duty;
  logic             pending_valid;

  // a capture on the wrap edge sets pending after the apply check, so it waits one more period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_duty   <= '0;
      pending_duty  <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (wrap && pending_valid) begin
        active_duty   <= pending_duty;
        pending_valid <= 1'b0;
      end
      if (capture) begin
        pending_duty  <= rv_duty_cycle;
        pending_valid <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          active_duty <= '0;
    else if (capture) active_duty <= rv_duty_cycle;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm <= 1'b0;
    else     pwm <= (counter < active_duty);
  end

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Directed bench for audio_pwm_dac: handshake latency, per-period high counts, wrap-edge capture, reset mid-handshake.
// Tracks the PWM counter from the reset-release edge count; windows close on the wrap edge.
module tb_audio_pwm_dac;
  localparam int WIDTH = 12;
  localparam int P     = 1 << WIDTH;
`ifdef AUDIO_PWM_DAC_DOUBLE_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] rv_duty_cycle = '0;
  logic             req = 1'b0;
  logic             ack;
  logic             pwm;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int hi_acc    = 0;
  int per_hi    = -1;
  logic first_pwm, last_pwm, ack_seen;

  audio_pwm_dac #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rv_duty_cycle(rv_duty_cycle), .req(req), .ack(ack), .pwm(pwm)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock edge; window k covers edges k*P+1 .. (k+1)*P after reset release
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (pwm === 1'b1) hi_acc++;
    if (ack === 1'b1) ack_seen = 1'b1;
    if (cyc % P == 1) first_pwm = pwm;
    last_pwm = pwm;
    if (cyc % P == 0) begin
      per_hi = hi_acc;
      hi_acc = 0;
    end
  endtask

  task automatic wait_wrap();
    step();
    while (cyc % P != 0) step();
  endtask

  task automatic advance_to(input int m);
    while (cyc % P != m) step();
  endtask

  task automatic raise(input logic [WIDTH-1:0] d, input string tag);
    rv_duty_cycle = d;
    req = 1'b1;
    step(); chk({tag, "_ack_e1"}, ack, 0);
    step(); chk({tag, "_ack_e2"}, ack, 0);
    step(); chk({tag, "_ack_e3"}, ack, 1);
  endtask

  task automatic drop(input string tag);
    req = 1'b0;
    step(); chk({tag, "_drop_e1"}, ack, 1);
    step(); chk({tag, "_drop_e2"}, ack, 1);
    step(); chk({tag, "_drop_e3"}, ack, 0);
  endtask

  initial begin
    ack_seen = 1'b0;
    first_pwm = 1'b0;
    last_pwm = 1'b0;
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_pwm", pwm, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // duty 0 for three full periods, no ack
    repeat (3) begin
      wait_wrap();
      chk("duty0_hi", per_hi, 0);
    end
    chk("duty0_noack", ack_seen, 0);

    raise(12'd1024, "d1024");
    drop("d1024");
    wait_wrap();
    wait_wrap();
    chk("d1024_hi", per_hi, 1024);
    chk("d1024_first", first_pwm, 1);

    raise(12'd4095, "d4095");
    drop("d4095");
    wait_wrap();
    wait_wrap();
    chk("d4095_hi", per_hi, 4095);
    chk("d4095_first", first_pwm, 1);
    chk("d4095_last", last_pwm, 0);

    raise(12'd1, "d1");
    drop("d1");
    wait_wrap();
    wait_wrap();
    chk("d1_hi", per_hi, 1);
    chk("d1_first", first_pwm, 1);

    // two requests inside one period; only the later one must show up
    raise(12'd500, "d500");
    drop("d500");
    raise(12'd3000, "d3000");
    drop("d3000");
    wait_wrap();
    chk("two_req_cur_hi", per_hi, BUF ? 1 : 2998);
    wait_wrap();
    chk("two_req_next_hi", per_hi, 3000);

    // capture lands exactly on the wrap edge
    advance_to(P - 3);
    raise(12'd200, "wrapcap");
    chk("wrapcap_on_wrap", cyc % P, 0);
    drop("wrapcap");
    wait_wrap();
    chk("wrapcap_p1_hi", per_hi, BUF ? 3000 : 200);
    wait_wrap();
    chk("wrapcap_p2_hi", per_hi, 200);

    // reset while acked with req held high
    raise(12'd2048, "pre_rst");
    rst = 1'b1;
    #1;
    chk("rst_mid_ack", ack, 0);
    chk("rst_mid_pwm", pwm, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    hi_acc = 0;
    step(); chk("rerq_e1", ack, 0);
    step(); chk("rerq_e2", ack, 0);
    step(); chk("rerq_e3", ack, 1);
    chk("rerq_pwm_e3", pwm, 0);
    drop("rerq");
    wait_wrap();
    chk("rerq_p0_hi", per_hi, BUF ? 0 : 2045);
    wait_wrap();
    chk("rerq_p1_hi", per_hi, 2048);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
